// File: rtl/adc_uart_reporter.sv
// Multi-channel ADC reporter: links to the host with an ACK echo, then answers one-shot or
// periodic read requests by strobing all ADCs and streaming tagged 2-byte words over UART.
module adc_uart_reporter #(
   parameter int         NUM_CH      = 2,
   parameter int         ADC_BITS    = 12,
   parameter int         AUTO_PERIOD = 48000000,
   parameter int         ADC_TIMEOUT = 4096,
   parameter logic [7:0] ACK_BYTE    = 8'h33,
   parameter logic [7:0] READ_CMD    = 8'h9B,
   parameter logic [7:0] AUTO_CMD    = 8'hA5,
   parameter logic [7:0] STOP_CMD    = 8'h5A,
   parameter logic [7:0] ERR_BYTE    = 8'hEE
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [7:0]                   rx_data,
   input  logic                         rx_done,
   input  logic                         parity_error,
   output logic [7:0]                   tx_data,
   output logic                         start_tx,
   input  logic                         tx_busy,
   output logic                         adc_read,
   input  logic [NUM_CH-1:0]            adc_done,
   input  logic [NUM_CH*ADC_BITS-1:0]   adc_value,
   output logic                         linked,
   output logic                         auto_mode,
   output logic                         timeout_err,
   output logic                         overrun
);

   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int TMR_W = $clog2(AUTO_PERIOD);
   localparam int TO_W  = $clog2(ADC_TIMEOUT + 1);
   localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(AUTO_PERIOD - 1);
   localparam logic [TO_W-1:0]  TO_LIMIT   = TO_W'(ADC_TIMEOUT);
   localparam logic [CH_W-1:0]  LAST_CH    = CH_W'(NUM_CH - 1);

   typedef enum logic [2:0] {
      S_UNLINKED, S_LINK_TX, S_IDLE, S_SAMPLE, S_SEND, S_SEND_WAIT, S_ERR_TX
   } state_t;

   state_t                      state_q, state_d;
   logic [1:0]                  tx_ph_q, tx_ph_d;
   logic                        linked_q, linked_d;
   logic                        auto_q, auto_d;
   logic                        pending_q, pending_d;
   logic                        overrun_q, overrun_d;
   logic [TMR_W-1:0]            timer_q, timer_d;
   logic [TO_W-1:0]             to_cnt_q, to_cnt_d;
   logic                        done_q, done_d;
   logic [CH_W-1:0]             ch_q, ch_d;
   logic                        lo_sel_q, lo_sel_d;
   logic [7:0]                  tx_data_q, tx_data_d;
   logic [NUM_CH*ADC_BITS-1:0]  val_q, val_d;

   logic       valid_rx;
   logic       tick;
   logic [7:0] tx_byte;
   logic [7:0] frame_byte;
   logic [7:0] hi_byte [NUM_CH];
   logic [7:0] lo_byte [NUM_CH];

   assign valid_rx = rx_done & ~parity_error;
   assign tick     = auto_q && (timer_q == '0);

   // The counter gate discards the adc_read cycle, where done may still be left over from the last conversion.
   assign done_d = (state_q == S_SAMPLE) && (to_cnt_q != '0) && (&adc_done);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [11:0] v_ext;
         assign v_ext       = 12'(val_q[gi*ADC_BITS +: ADC_BITS]);
         assign hi_byte[gi] = {4'(gi), v_ext[11:8]};
         assign lo_byte[gi] = v_ext[7:0];
      end
   endgenerate

   assign frame_byte = lo_sel_q ? lo_byte[ch_q] : hi_byte[ch_q];

   always_comb begin
      state_d     = state_q;
      tx_ph_d     = tx_ph_q;
      linked_d    = linked_q;
      auto_d      = auto_q;
      pending_d   = pending_q;
      overrun_d   = overrun_q;
      timer_d     = timer_q;
      to_cnt_d    = to_cnt_q;
      ch_d        = ch_q;
      lo_sel_d    = lo_sel_q;
      tx_data_d   = tx_data_q;
      val_d       = val_q;
      start_tx    = 1'b0;
      tx_byte     = tx_data_q;
      adc_read    = 1'b0;
      timeout_err = 1'b0;

      if (auto_q) begin
         timer_d = tick ? TMR_RELOAD : timer_q - 1'b1;
      end

      case (state_q)
         S_UNLINKED: begin
            if (valid_rx && rx_data == ACK_BYTE) begin
               state_d = S_LINK_TX;
               tx_ph_d = 2'd0;
            end
         end
         S_LINK_TX, S_ERR_TX: begin
            if (tx_ph_q == 2'd0) begin
               start_tx = 1'b1;
               tx_byte  = (state_q == S_LINK_TX) ? ACK_BYTE : ERR_BYTE;
               tx_ph_d  = 2'd1;
            end else if (tx_ph_q == 2'd1) begin
               tx_ph_d = 2'd2;
            end else if (!tx_busy) begin
               tx_ph_d = 2'd0;
               state_d = S_IDLE;
               if (state_q == S_LINK_TX) begin
                  linked_d = 1'b1;
               end
            end
         end
         S_IDLE: begin
            if (pending_q) begin
               state_d   = S_SAMPLE;
               pending_d = tick;
            end else if (tick) begin
               state_d = S_SAMPLE;
            end else if (valid_rx && rx_data == READ_CMD) begin
               state_d = S_SAMPLE;
            end else if (valid_rx && rx_data == ACK_BYTE) begin
               state_d = S_LINK_TX;
               tx_ph_d = 2'd0;
            end
         end
         S_SAMPLE: begin
            adc_read = (to_cnt_q == '0);
            if (done_q) begin
               val_d    = adc_value;
               ch_d     = '0;
               lo_sel_d = 1'b0;
               state_d  = S_SEND;
            end else if (to_cnt_q == TO_LIMIT) begin
               timeout_err = 1'b1;
               state_d     = S_ERR_TX;
               tx_ph_d     = 2'd0;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         S_SEND: begin
            start_tx = 1'b1;
            tx_byte  = frame_byte;
            tx_ph_d  = 2'd1;
            state_d  = S_SEND_WAIT;
         end
         S_SEND_WAIT: begin
            if (tx_ph_q == 2'd1) begin
               tx_ph_d = 2'd2;
            end else if (!tx_busy) begin
               tx_ph_d = 2'd0;
               if (!lo_sel_q) begin
                  lo_sel_d = 1'b1;
                  state_d  = S_SEND;
               end else if (ch_q == LAST_CH) begin
                  state_d = S_IDLE;
               end else begin
                  ch_d     = ch_q + 1'b1;
                  lo_sel_d = 1'b0;
                  state_d  = S_SEND;
               end
            end
         end
         default: state_d = S_UNLINKED;
      endcase

      // A tick that cannot be served now is remembered once; a second one is an overrun.
      if (tick && state_q != S_IDLE && state_q != S_UNLINKED) begin
         if (pending_q) begin
            overrun_d = 1'b1;
         end else begin
            pending_d = 1'b1;
         end
      end

      if (valid_rx && state_q != S_UNLINKED) begin
         if (rx_data == STOP_CMD) begin
            auto_d    = 1'b0;
            pending_d = 1'b0;
         end else if (rx_data == AUTO_CMD) begin
            auto_d  = 1'b1;
            timer_d = TMR_RELOAD;
         end
      end

      if (state_d == S_SAMPLE && state_q != S_SAMPLE) begin
         to_cnt_d = '0;
      end

      if (start_tx) begin
         tx_data_d = tx_byte;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_UNLINKED;
         tx_ph_q   <= 2'd0;
         linked_q  <= 1'b0;
         auto_q    <= 1'b0;
         pending_q <= 1'b0;
         overrun_q <= 1'b0;
         timer_q   <= '0;
         to_cnt_q  <= '0;
         done_q    <= 1'b0;
         ch_q      <= '0;
         lo_sel_q  <= 1'b0;
         tx_data_q <= 8'h00;
         val_q     <= '0;
      end else begin
         state_q   <= state_d;
         tx_ph_q   <= tx_ph_d;
         linked_q  <= linked_d;
         auto_q    <= auto_d;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
         timer_q   <= timer_d;
         to_cnt_q  <= to_cnt_d;
         done_q    <= done_d;
         ch_q      <= ch_d;
         lo_sel_q  <= lo_sel_d;
         tx_data_q <= tx_data_d;
         val_q     <= val_d;
      end
   end

   assign tx_data   = tx_byte;
   assign linked    = linked_q;
   assign auto_mode = auto_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_adc_uart_reporter.sv
// Scoreboard bench for adc_uart_reporter: expected UART bytes are queued when a command is
// driven and popped as start_tx strobes appear; a small UART and ADC model close the loop.
module tb_adc_uart_reporter;

   localparam int NUM_CH      = 2;
   localparam int ADC_BITS    = 12;
   localparam int AUTO_PERIOD = 100;
   localparam int ADC_TIMEOUT = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                        reset;
   logic [7:0]                  rx_data;
   logic                        rx_done;
   logic                        parity_error;
   logic [7:0]                  tx_data;
   logic                        start_tx;
   logic                        tx_busy;
   logic                        adc_read;
   logic [NUM_CH-1:0]           adc_done;
   logic [NUM_CH*ADC_BITS-1:0]  adc_value;
   logic                        linked;
   logic                        auto_mode;
   logic                        timeout_err;
   logic                        overrun;

   adc_uart_reporter #(
      .NUM_CH      (NUM_CH),
      .ADC_BITS    (ADC_BITS),
      .AUTO_PERIOD (AUTO_PERIOD),
      .ADC_TIMEOUT (ADC_TIMEOUT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .rx_data      (rx_data),
      .rx_done      (rx_done),
      .parity_error (parity_error),
      .tx_data      (tx_data),
      .start_tx     (start_tx),
      .tx_busy      (tx_busy),
      .adc_read     (adc_read),
      .adc_done     (adc_done),
      .adc_value    (adc_value),
      .linked       (linked),
      .auto_mode    (auto_mode),
      .timeout_err  (timeout_err),
      .overrun      (overrun)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   logic [7:0] exp_q [$];

   int n_read = 0, n_tx = 0, n_to = 0;
   int read_cyc = 0, tx_cyc = 0, to_cyc = 0, done_cyc = 0;
   int stall = 4;
   int busy_cnt = 0;
   int adc_lat = 3;
   bit adc_hang = 1'b0;
   int conv_cnt = 0;
   logic done_lvl = 1'b0;

   assign tx_busy  = (busy_cnt != 0);
   assign adc_done = {NUM_CH{done_lvl}};

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor plus UART/ADC models, all evaluated mid-cycle.
   always @(negedge clk) begin
      if (adc_read) begin
         n_read++;
         read_cyc = cyc;
         conv_cnt = adc_lat;
         done_lvl = 1'b0;
      end else if (conv_cnt > 0) begin
         conv_cnt--;
         if (conv_cnt == 0 && !adc_hang) begin
            done_lvl = 1'b1;
            done_cyc = cyc;
         end
      end
      if (timeout_err) begin
         n_to++;
         to_cyc = cyc;
      end
      if (start_tx) begin
         n_tx++;
         tx_cyc = cyc;
         $display("[TB] cyc %0d tx byte 0x%02h", cyc, tx_data);
         chk_eq("tx_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) chk_eq("tx_byte", tx_data, exp_q.pop_front());
         busy_cnt = stall;
      end else if (busy_cnt > 0) begin
         busy_cnt--;
      end
   end

   task automatic tick_n(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic par);
      @(posedge clk); #1;
      rx_data = b; rx_done = 1'b1; parity_error = par;
      @(posedge clk); #1;
      rx_done = 1'b0; parity_error = 1'b0;
   endtask

   task automatic push_frame(input logic [11:0] v0, input logic [11:0] v1);
      exp_q.push_back({4'd0, v0[11:8]});
      exp_q.push_back(v0[7:0]);
      exp_q.push_back({4'd1, v1[11:8]});
      exp_q.push_back(v1[7:0]);
   endtask

   task automatic wait_drain(input string tag, input int lim);
      int b = 0;
      while (exp_q.size() != 0 && b < lim) begin
         @(posedge clk); #1; b++;
      end
      chk_eq(tag, exp_q.size(), 0);
      tick_n(stall + 4);
   endtask

   task automatic wait_read(input string tag, input int prev, input int lim);
      int b = 0;
      while (n_read == prev && b < lim) begin
         @(posedge clk); #1; b++;
      end
      chk_eq(tag, n_read, prev + 1);
   endtask

   task automatic wait_tx(input string tag, input int prev, input int lim);
      int b = 0;
      while (n_tx == prev && b < lim) begin
         @(posedge clk); #1; b++;
      end
      chk_eq(tag, n_tx, prev + 1);
   endtask

   initial begin
      int prev, prev_cyc, b;
      reset = 1'b1; rx_data = 8'h00; rx_done = 1'b0; parity_error = 1'b0; adc_value = '0;
      tick_n(3);
      chk_eq("reset_outs", {tx_data, start_tx, adc_read, linked, auto_mode, timeout_err, overrun}, 0);
      reset = 1'b0;
      tick_n(2);

      // Parity-errored ACK is ignored
      send_byte(8'h33, 1'b1);
      tick_n(10);
      chk_eq("par_linked", linked, 0);
      chk_eq("par_notx", n_tx, 0);

      // READ before link is dropped, ACK is echoed once
      send_byte(8'h9B, 1'b0);
      tick_n(10);
      chk_eq("unl_noread", n_read, 0);
      chk_eq("unl_notx", n_tx, 0);
      exp_q.push_back(8'h33);
      send_byte(8'h33, 1'b0);
      wait_drain("link_drain", 50);
      chk_eq("link_linked", linked, 1);
      chk_eq("link_ntx", n_tx, 1);

      // One-shot read; bus changes after latching must not leak into the frame
      adc_value = {12'h123, 12'hABC};
      push_frame(12'hABC, 12'h123);
      prev = n_read;
      send_byte(8'h9B, 1'b0);
      chk_eq("rd_latency", adc_read, 1);
      wait_tx("rd_first_tx", n_tx, 100);
      chk_eq("done2tx", tx_cyc - done_cyc, 2);
      adc_value = {12'h666, 12'h555};
      wait_drain("rd_drain", 200);
      chk_eq("rd_one_pulse", n_read, prev + 1);

      adc_value = {12'hFFF, 12'h000};
      push_frame(12'h000, 12'hFFF);
      prev = n_read;
      send_byte(8'h9B, 1'b0);
      wait_drain("rd2_drain", 200);
      chk_eq("rd2_one_pulse", n_read, prev + 1);

      // Unknown byte ignored; ACK re-echoed while linked
      prev = n_tx;
      send_byte(8'h00, 1'b0);
      tick_n(10);
      chk_eq("junk_notx", n_tx, prev);
      exp_q.push_back(8'h33);
      send_byte(8'h33, 1'b0);
      wait_drain("reecho_drain", 50);

      // ADC timeout
      adc_hang = 1'b1;
      exp_q.push_back(8'hEE);
      prev = n_to;
      send_byte(8'h9B, 1'b0);
      b = 0;
      while (n_to == prev && b < 200) begin
         @(posedge clk); #1; b++;
      end
      chk_eq("to_pulse", n_to, prev + 1);
      chk_eq("to_cycle", to_cyc - read_cyc, ADC_TIMEOUT);
      wait_drain("to_drain", 50);
      adc_hang = 1'b0;
      adc_value = {12'h456, 12'h789};
      push_frame(12'h789, 12'h456);
      send_byte(8'h9B, 1'b0);
      wait_drain("after_to_drain", 200);

      // Periodic mode
      adc_value = {12'h321, 12'h7F0};
      chk_eq("ovr_clear", overrun, 0);
      send_byte(8'hA5, 1'b0);
      chk_eq("auto_on", auto_mode, 1);
      for (int k = 0; k < 3; k++) begin
         push_frame(12'h7F0, 12'h321);
         prev = n_read;
         prev_cyc = read_cyc;
         wait_read("auto_read", prev, 150);
         if (k > 0) chk_eq("auto_period", read_cyc - prev_cyc, AUTO_PERIOD);
      end
      wait_drain("auto_drain", 200);
      stall = 250;
      push_frame(12'h7F0, 12'h321);
      prev = n_read;
      prev_cyc = read_cyc;
      wait_read("stall_read", prev, 150);
      chk_eq("stall_period", read_cyc - prev_cyc, AUTO_PERIOD);
      b = 0;
      while (!overrun && b < 400) begin
         @(posedge clk); #1; b++;
      end
      chk_eq("overrun_set", overrun, 1);
      send_byte(8'h5A, 1'b0);
      chk_eq("auto_off", auto_mode, 0);
      wait_drain("stop_drain", 1500);
      prev = n_read;
      tick_n(300);
      chk_eq("stop_noread", n_read, prev);
      chk_eq("overrun_sticky", overrun, 1);
      stall = 4;

      // Reset in the middle of a frame
      adc_value = {12'hBAD, 12'hCAF};
      push_frame(12'hCAF, 12'hBAD);
      send_byte(8'h9B, 1'b0);
      wait_tx("mid_first_tx", n_tx, 100);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      chk_eq("midrst_outs", {tx_data, start_tx, adc_read, linked, auto_mode, timeout_err, overrun}, 0);
      exp_q.delete();
      reset = 1'b0;
      prev = n_read;
      send_byte(8'h9B, 1'b0);
      tick_n(20);
      chk_eq("midrst_noread", n_read, prev);
      chk_eq("midrst_unlinked", linked, 0);
      exp_q.push_back(8'h33);
      send_byte(8'h33, 1'b0);
      wait_drain("relink_drain", 300);
      chk_eq("relinked", linked, 1);

      chk_eq("final_queue", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
